// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the nibble CPU.
// Owns the PC, reads a combinational 5-bit/8-bit instruction memory,
// assembles one- or two-byte instructions and presents each over a
// valid/ready handshake. Jumps redirect the PC; the halt opcode stops
// fetching once delivered.
module instr_fetch_unit #(
  parameter logic [15:0] TWO_BYTE_MASK = 16'h000D,
  parameter logic [3:0]  HALT_OPC      = 4'h1,
  parameter logic [4:0]  RESET_PC      = 5'd0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] instr_opcode,
  output logic [3:0] instr_operand,
  output logic [7:0] instr_imm,
  output logic       instr_two_byte,
  output logic [4:0] instr_pc,
  input  logic       jmp_valid,
  input  logic [4:0] jmp_addr,
  output logic       halted
);

  typedef enum logic [1:0] {
    FETCH0  = 2'd0,
    FETCH1  = 2'd1,
    PRESENT = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] pc;

  // The memory address is always the current PC; the memory answers
  // combinationally, so data is captured on the same edge.
  assign mem_addr = pc;

  // Fetch state machine with all instruction outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= FETCH0;
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      instr_opcode   <= 4'h0;
      instr_operand  <= 4'h0;
      instr_imm      <= 8'h00;
      instr_two_byte <= 1'b0;
      instr_pc       <= 5'd0;
      halted         <= 1'b0;
    end else if (jmp_valid) begin
      // A redirect beats everything, including a pending halt transition;
      // any half-fetched or unaccepted instruction is dropped.
      state       <= FETCH0;
      pc          <= jmp_addr;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH0: begin
          instr_opcode  <= mem_data[7:4];
          instr_operand <= mem_data[3:0];
          instr_pc      <= pc;
          pc            <= pc + 5'd1;
          if (TWO_BYTE_MASK[mem_data[7:4]]) begin
            state <= FETCH1;
          end else begin
            instr_imm      <= 8'h00;
            instr_two_byte <= 1'b0;
            instr_valid    <= 1'b1;
            state          <= PRESENT;
          end
        end
        FETCH1: begin
          // PC wraps naturally from 31 to 0 for the immediate byte.
          instr_imm      <= mem_data;
          instr_two_byte <= 1'b1;
          pc             <= pc + 5'd1;
          instr_valid    <= 1'b1;
          state          <= PRESENT;
        end
        PRESENT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instr_opcode == HALT_OPC) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= FETCH0;
            end
          end
        end
        HALTED: begin
          // PC frozen; only a jump or reset leaves this state.
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state <= FETCH0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: a small ROM model answers
// mem_addr combinationally; each scenario task checks its own results.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_opcode;
  logic [3:0] instr_operand;
  logic [7:0] instr_imm;
  logic       instr_two_byte;
  logic [4:0] instr_pc;
  logic       jmp_valid;
  logic [4:0] jmp_addr;
  logic       halted;

  logic [7:0] rom [0:31];
  int total;
  int bad;

  instr_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_opcode(instr_opcode),
    .instr_operand(instr_operand),
    .instr_imm(instr_imm),
    .instr_two_byte(instr_two_byte),
    .instr_pc(instr_pc),
    .jmp_valid(jmp_valid),
    .jmp_addr(jmp_addr),
    .halted(halted)
  );

  assign mem_data = rom[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) at negedges until an instruction is presented.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Accept the presented instruction on the next rising edge.
  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_ready = 1'b0;
    jmp_valid = 1'b0;
    jmp_addr = 5'd0;
    repeat (2) @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", instr_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0h exp=0", halted); end
    total++; if (mem_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    total++; if ({instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc} !== 22'd0) begin
      bad++; $display("FAIL reset_fields got=%0h/%0h/%0h/%0h/%0h exp=0", instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc);
    end
    reset = 1'b0;
    $display("reset released, mem_addr=%0d", mem_addr);
  endtask

  task automatic test_sequence_and_stall();
    bit ok;
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL beat1_timeout got=0 exp=1"); end
    total++; if ({instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc} !== {4'h3, 4'h9, 8'h00, 1'b1, 5'd0}) begin
      bad++; $display("FAIL beat1 got=%0h/%0h/%0h/%0h/%0d exp=3/9/0/1/0", instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc);
    end
    $display("beat1 op=%0h opd=%0h imm=%0h pc=%0d", instr_opcode, instr_operand, instr_imm, instr_pc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({instr_valid, instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc, mem_addr} !== {1'b1, 4'h3, 4'h9, 8'h00, 1'b1, 5'd0, 5'd2}) begin
        bad++; $display("FAIL stall_cycle%0d got v=%0h op=%0h addr=%0d exp v=1 op=3 addr=2", i, instr_valid, instr_opcode, mem_addr);
      end
    end
    accept();
    total++; if ({instr_valid, mem_addr} !== {1'b0, 5'd2}) begin
      bad++; $display("FAIL after_accept got v=%0h addr=%0d exp v=0 addr=2", instr_valid, mem_addr);
    end
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL beat2_timeout got=0 exp=1"); end
    total++; if ({instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc} !== {4'h3, 4'h2, 8'h01, 1'b1, 5'd2}) begin
      bad++; $display("FAIL beat2 got=%0h/%0h/%0h/%0h/%0d exp=3/2/1/1/2", instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc);
    end
    $display("beat2 op=%0h opd=%0h imm=%0h pc=%0d", instr_opcode, instr_operand, instr_imm, instr_pc);
    accept();
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL beat3_timeout got=0 exp=1"); end
    total++; if ({instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc} !== {4'hA, 4'h6, 8'h00, 1'b0, 5'd4}) begin
      bad++; $display("FAIL beat3 got=%0h/%0h/%0h/%0h/%0d exp=a/6/0/0/4", instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc);
    end
    $display("beat3 op=%0h opd=%0h imm=%0h pc=%0d", instr_opcode, instr_operand, instr_imm, instr_pc);
    accept();
  endtask

  task automatic test_jump_mid_fetch();
    bit ok;
    // FETCH0 at 5 now; next edge latches 0x20 (two-byte) and enters FETCH1.
    @(negedge clk);
    total++; if ({instr_valid, mem_addr} !== {1'b0, 5'd6}) begin
      bad++; $display("FAIL fetch1_state got v=%0h addr=%0d exp v=0 addr=6", instr_valid, mem_addr);
    end
    jmp_valid = 1'b1;
    jmp_addr = 5'd9;
    @(negedge clk);
    jmp_valid = 1'b0;
    total++; if ({instr_valid, mem_addr} !== {1'b0, 5'd9}) begin
      bad++; $display("FAIL jump_redirect got v=%0h addr=%0d exp v=0 addr=9", instr_valid, mem_addr);
    end
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL jump_timeout got=0 exp=1"); end
    total++; if ({instr_opcode, instr_operand, instr_two_byte, instr_pc} !== {4'h8, 4'h5, 1'b0, 5'd9}) begin
      bad++; $display("FAIL jump_beat got=%0h/%0h/%0h/%0d exp=8/5/0/9", instr_opcode, instr_operand, instr_two_byte, instr_pc);
    end
    $display("jump beat op=%0h opd=%0h pc=%0d", instr_opcode, instr_operand, instr_pc);
    accept();
  endtask

  task automatic test_halt();
    bit ok;
    for (int a = 10; a <= 16; a++) begin
      wait_valid(ok);
      total++; if (!ok || instr_pc !== 5'(a)) begin
        bad++; $display("FAIL walk_pc got=%0d exp=%0d", instr_pc, a);
      end
      $display("walk beat op=%0h pc=%0d", instr_opcode, instr_pc);
      accept();
    end
    for (int i = 0; i < 10; i++) begin
      total++; if ({halted, instr_valid, mem_addr} !== {1'b1, 1'b0, 5'd17}) begin
        bad++; $display("FAIL halted_cycle%0d got h=%0h v=%0h addr=%0d exp h=1 v=0 addr=17", i, halted, instr_valid, mem_addr);
      end
      @(negedge clk);
    end
    jmp_valid = 1'b1;
    jmp_addr = 5'd0;
    @(negedge clk);
    jmp_valid = 1'b0;
    total++; if ({halted, mem_addr} !== {1'b0, 5'd0}) begin
      bad++; $display("FAIL unhalt got h=%0h addr=%0d exp h=0 addr=0", halted, mem_addr);
    end
    wait_valid(ok);
    total++; if (!ok || {instr_opcode, instr_operand, instr_pc} !== {4'h3, 4'h9, 5'd0}) begin
      bad++; $display("FAIL refetch0 got=%0h/%0h/%0d exp=3/9/0", instr_opcode, instr_operand, instr_pc);
    end
    $display("after halt jump op=%0h pc=%0d", instr_opcode, instr_pc);
    accept();
  endtask

  task automatic test_wrap();
    bit ok;
    rom[0] = 8'h55;
    jmp_valid = 1'b1;
    jmp_addr = 5'd31;
    @(negedge clk);
    jmp_valid = 1'b0;
    wait_valid(ok);
    total++; if (!ok || {instr_opcode, instr_imm, instr_two_byte, instr_pc, mem_addr} !== {4'h0, 8'h55, 1'b1, 5'd31, 5'd1}) begin
      bad++; $display("FAIL wrap got op=%0h imm=%0h tb=%0h pc=%0d addr=%0d exp op=0 imm=55 tb=1 pc=31 addr=1",
                      instr_opcode, instr_imm, instr_two_byte, instr_pc, mem_addr);
    end
    $display("wrap beat imm=%0h pc=%0d", instr_imm, instr_pc);
    accept();
    total++; if (mem_addr !== 5'd1) begin bad++; $display("FAIL wrap_next got=%0d exp=1", mem_addr); end
    rom[0] = 8'h39;
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL pre_reset_timeout got=0 exp=1"); end
    #2 reset = 1'b1;
    #1;
    total++; if ({instr_valid, mem_addr, halted} !== {1'b0, 5'd0, 1'b0}) begin
      bad++; $display("FAIL async_reset got v=%0h addr=%0d h=%0h exp v=0 addr=0 h=0", instr_valid, mem_addr, halted);
    end
    $display("async reset v=%0h addr=%0d", instr_valid, mem_addr);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(ok);
    total++; if (!ok || {instr_opcode, instr_operand, instr_pc} !== {4'h3, 4'h9, 5'd0}) begin
      bad++; $display("FAIL post_reset got=%0h/%0h/%0d exp=3/9/0", instr_opcode, instr_operand, instr_pc);
    end
    $display("post reset op=%0h pc=%0d", instr_opcode, instr_pc);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h39; rom[1] = 8'h00; rom[2] = 8'h32; rom[3] = 8'h01;
    rom[4] = 8'hA6; rom[5] = 8'h20; rom[6] = 8'h77; rom[7] = 8'h40;
    rom[8] = 8'h40; rom[9] = 8'h85;
    for (int i = 10; i < 16; i++) rom[i] = 8'h40 + 8'(i);
    rom[16] = 8'h1F;
    reset = 1'b1;
    instr_ready = 1'b0;
    jmp_valid = 1'b0;
    jmp_addr = 5'd0;
    @(negedge clk);
    test_reset();
    test_sequence_and_stall();
    test_jump_mid_fetch();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
